tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter W, default 8: data width of the serial channel and of each output lane.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 din  input  W  time-multiplexed data beat.
REQ-005 din_valid  input  1  din carries a beat this cycle.
REQ-006 frame_sync  input  1  qualified by din_valid; marks the beat as slot 0, lane a.
REQ-007 y_a, y_b, y_c, y_d  output  W each  registered lanes for slots 0..3.
REQ-008 frame_valid  output  1  one-cycle pulse when y_a..y_d update together.
REQ-009 locked  output  1  high in state LOCKED.
REQ-010 sync_err  output  1  one-cycle pulse on a framing violation.
REQ-011 slot  output  2  next expected slot index {s1,s0}.

Function
REQ-012 The block SHALL have two states: HUNT and LOCKED.
REQ-013 HUNT: beats with din_valid=1 and frame_sync=0 SHALL be discarded without error.
REQ-014 HUNT: a beat with din_valid=1 and frame_sync=1 SHALL be captured into shadow slot 0, set slot=1, and enter LOCKED.
REQ-015 LOCKED: each din_valid beat without frame_sync, with slot!=0, SHALL be captured into shadow[slot]; slot SHALL increment modulo 4 (3 wraps to 0).
REQ-016 Capture of the slot-3 beat SHALL copy shadow 0..2 plus that beat into y_a..y_d in the same edge; frame_valid SHALL be 1 for exactly the following cycle (latency 1 cycle from the slot-3 beat).
REQ-017 Outputs y_a..y_d SHALL hold their values between frames; partial frames SHALL never reach them.
REQ-018 LOCKED, slot=0, beat with frame_sync=1: normal start of frame; capture into shadow 0, slot=1.
REQ-019 LOCKED, slot!=0, beat with frame_sync=1 (early sync): sync_err pulses; the partial frame is discarded; the beat is captured as slot 0, slot=1; remain LOCKED.
REQ-020 LOCKED, slot=0, beat with frame_sync=0 (missing sync): sync_err pulses; the beat is discarded; enter HUNT; slot=0.
REQ-021 Cycles with din_valid=0 SHALL change no state; frame_sync is ignored when din_valid=0.
REQ-022 frame_valid and sync_err SHALL never be high in the same cycle; a beat triggers at most one of them.
REQ-023 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL enter HUNT with slot=0, shadow registers and y_a..y_d =0, and frame_valid=sync_err=locked=0.
REQ-025 rst SHALL take priority over din_valid on the same edge; a frame in progress SHALL be abandoned without a pulse.

Structure
REQ-026 Package tdm_pkg SHALL hold NUM_CH=4, SLOT_W=2, and the state enum type {HUNT, LOCKED}.
REQ-027 One sub-module, tdm_slot_ctr, SHALL implement the 2-bit wrap counter with clear (load 1) and enable inputs.

Verification
REQ-028 Reset, then beats 0x11(sync), 0x22, 0x33, 0x44 -> one cycle after 0x44: y_a..y_d = 11/22/33/44, frame_valid=1 for one cycle, locked=1.
REQ-029 In HUNT, beats 0xAA, 0xBB without sync -> no outputs change, sync_err=0, locked=0.
REQ-030 Beats 0x01(sync), 0x02, then 0x05(sync), 0x06, 0x07, 0x08 -> sync_err pulses on the 0x05 beat; next frame_valid gives y = 05/06/07/08.
REQ-031 After a complete frame, beat 0x99 without sync -> sync_err=1, locked=0; y keeps its previous frame.
REQ-032 Full frame with din_valid low on alternate cycles -> same result as REQ-028; slot advances only on valid beats.
REQ-033 rst=1 asserted after the slot-2 beat, then a full frame 0x10..0x13 -> no frame_valid before it; y = 10/11/12/13 afterwards.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and types for the four-slot TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  // True when the given slot index is the final slot of a frame.
  function automatic logic is_last_slot(input logic [SLOT_W-1:0] s);
    return s == SLOT_W'(NUM_CH - 1);
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial beat input and demultiplexed lane outputs of tdm_demux4, plus FSM debug state.
interface tdm_demux4_if #(parameter int W = 8);
  import tdm_pkg::*;

  // din/frame_sync are meaningful only when din_valid=1; there is no ready,
  // the demux accepts every valid beat on the clock edge where it is presented.
  logic [W-1:0]      din;
  logic              din_valid;
  logic              frame_sync;

  logic [W-1:0]      y_a;
  logic [W-1:0]      y_b;
  logic [W-1:0]      y_c;
  logic [W-1:0]      y_d;
  logic              frame_valid;
  logic              locked;
  logic              sync_err;
  logic [SLOT_W-1:0] slot;
  tdm_state_t        state;

  modport master (
    output din, din_valid, frame_sync,
    input  y_a, y_b, y_c, y_d, frame_valid, locked, sync_err, slot, state
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y_a, y_b, y_c, y_d, frame_valid, locked, sync_err, slot, state
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Next-expected-slot counter: clear loads 1 (the sync beat is slot 0), enable wraps modulo NUM_CH.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [SLOT_W-1:0] slot
);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (clr) begin
      slot <= SLOT_W'(1);
    end else if (en) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: collects a frame into shadow registers and
// publishes all four lanes atomically when the slot-3 beat arrives.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux4_if.slave   bus
);

  tdm_state_t        state_q;
  tdm_state_t        state_d;
  logic [SLOT_W-1:0] slot_q;

  logic              ctr_clr;
  logic              ctr_en;
  logic              cap_first;
  logic              cap_mid;
  logic              publish;
  logic              err_d;

  logic [W-1:0]      sh_a;
  logic [W-1:0]      sh_b;
  logic [W-1:0]      sh_c;
  logic [W-1:0]      y_a_q;
  logic [W-1:0]      y_b_q;
  logic [W-1:0]      y_c_q;
  logic [W-1:0]      y_d_q;
  logic              frame_valid_q;
  logic              sync_err_q;

  tdm_slot_ctr u_slot_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .en   (ctr_en),
    .slot (slot_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // In HUNT the slot counter is always 0, so a sync beat simply restarts it.
  always_comb begin
    state_d   = state_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    cap_first = 1'b0;
    cap_mid   = 1'b0;
    publish   = 1'b0;
    err_d     = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            cap_first = 1'b1;
            ctr_clr   = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            // Early sync abandons the partial frame and restarts at slot 0.
            cap_first = 1'b1;
            ctr_clr   = 1'b1;
            err_d     = (slot_q != '0);
          end else if (slot_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            ctr_en = 1'b1;
            if (is_last_slot(slot_q)) begin
              publish = 1'b1;
            end else begin
              cap_mid = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a          <= '0;
      sh_b          <= '0;
      sh_c          <= '0;
      y_a_q         <= '0;
      y_b_q         <= '0;
      y_c_q         <= '0;
      y_d_q         <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      if (cap_first) begin
        sh_a <= bus.din;
      end
      if (cap_mid) begin
        if (slot_q == SLOT_W'(1)) begin
          sh_b <= bus.din;
        end else begin
          sh_c <= bus.din;
        end
      end
      // Lanes only change here, so a partial frame can never leak out.
      if (publish) begin
        y_a_q <= sh_a;
        y_b_q <= sh_b;
        y_c_q <= sh_c;
        y_d_q <= bus.din;
      end
      frame_valid_q <= publish;
      sync_err_q    <= err_d;
    end
  end

  assign bus.y_a         = y_a_q;
  assign bus.y_b         = y_b_q;
  assign bus.y_c         = y_c_q;
  assign bus.y_d         = y_d_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.slot        = slot_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: hand-computed vectors checked with immediate assertions.
module tb_tdm_demux4;
  import tdm_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  tdm_demux4_if #(.W(8)) bus ();

  tdm_demux4 #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    bus.din        = d;
    bus.din_valid  = 1'b1;
    bus.frame_sync = s;
    tick();
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  // Idle cycle with frame_sync driven high to show it is ignored without din_valid.
  task automatic idle_sync_high();
    bus.din        = 8'hEE;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b1;
    tick();
    bus.frame_sync = 1'b0;
  endtask

  // Scoreboard checks
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    chk({tag, ".y_a"}, bus.y_a, a);
    chk({tag, ".y_b"}, bus.y_b, b);
    chk({tag, ".y_c"}, bus.y_c, c);
    chk({tag, ".y_d"}, bus.y_d, d);
  endtask

  task automatic chk_flags(input string tag, input logic fv, input logic se,
                           input logic lk, input logic [1:0] sl);
    chk({tag, ".frame_valid"}, 8'(bus.frame_valid), 8'(fv));
    chk({tag, ".sync_err"},    8'(bus.sync_err),    8'(se));
    chk({tag, ".locked"},      8'(bus.locked),      8'(lk));
    chk({tag, ".slot"},        8'(bus.slot),        8'(sl));
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_y("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset.state", 8'(bus.state), 8'(HUNT));

    // HUNT discards unsynced beats silently
    send(8'hAA, 1'b0);
    chk_flags("hunt_aa", 1'b0, 1'b0, 1'b0, 2'd0);
    send(8'hBB, 1'b0);
    chk_flags("hunt_bb", 1'b0, 1'b0, 1'b0, 2'd0);
    chk_y("hunt_bb", 8'h00, 8'h00, 8'h00, 8'h00);

    // Basic frame
    send(8'h11, 1'b1);
    chk_flags("f1_s0", 1'b0, 1'b0, 1'b1, 2'd1);
    chk("f1_s0.state", 8'(bus.state), 8'(LOCKED));
    send(8'h22, 1'b0);
    chk_flags("f1_s1", 1'b0, 1'b0, 1'b1, 2'd2);
    send(8'h33, 1'b0);
    chk_flags("f1_s2", 1'b0, 1'b0, 1'b1, 2'd3);
    chk_y("f1_s2", 8'h00, 8'h00, 8'h00, 8'h00);
    send(8'h44, 1'b0);
    chk_flags("f1_s3", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_y("f1_s3", 8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    chk_flags("f1_after", 1'b0, 1'b0, 1'b1, 2'd0);
    chk_y("f1_after", 8'h11, 8'h22, 8'h33, 8'h44);

    // Early sync aborts the partial frame
    send(8'h01, 1'b1);
    chk_flags("es_01", 1'b0, 1'b0, 1'b1, 2'd1);
    send(8'h02, 1'b0);
    chk_flags("es_02", 1'b0, 1'b0, 1'b1, 2'd2);
    send(8'h05, 1'b1);
    chk_flags("es_05", 1'b0, 1'b1, 1'b1, 2'd1);
    chk_y("es_05", 8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    chk_flags("es_idle", 1'b0, 1'b0, 1'b1, 2'd1);
    send(8'h06, 1'b0);
    send(8'h07, 1'b0);
    chk_flags("es_07", 1'b0, 1'b0, 1'b1, 2'd3);
    send(8'h08, 1'b0);
    chk_flags("es_08", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_y("es_08", 8'h05, 8'h06, 8'h07, 8'h08);

    // Missing sync drops to HUNT, lanes keep last frame
    send(8'h99, 1'b0);
    chk_flags("ms_99", 1'b0, 1'b1, 1'b0, 2'd0);
    chk_y("ms_99", 8'h05, 8'h06, 8'h07, 8'h08);
    tick();
    chk_flags("ms_idle", 1'b0, 1'b0, 1'b0, 2'd0);

    // Frame with idle cycles between beats
    send(8'h11, 1'b1);
    idle_sync_high();
    chk_flags("gap_s0", 1'b0, 1'b0, 1'b1, 2'd1);
    send(8'h22, 1'b0);
    idle_sync_high();
    chk_flags("gap_s1", 1'b0, 1'b0, 1'b1, 2'd2);
    send(8'h33, 1'b0);
    idle_sync_high();
    chk_flags("gap_s2", 1'b0, 1'b0, 1'b1, 2'd3);
    chk_y("gap_s2", 8'h05, 8'h06, 8'h07, 8'h08);
    send(8'h44, 1'b0);
    chk_flags("gap_s3", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_y("gap_s3", 8'h11, 8'h22, 8'h33, 8'h44);
    idle_sync_high();
    chk_flags("gap_after", 1'b0, 1'b0, 1'b1, 2'd0);

    // Reset mid-frame abandons it without a pulse
    send(8'h50, 1'b1);
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    bus.din        = 8'h53;
    bus.din_valid  = 1'b1;
    bus.frame_sync = 1'b0;
    rst            = 1'b1;
    tick();
    bus.din_valid  = 1'b0;
    rst            = 1'b0;
    chk_flags("rst_mid", 1'b0, 1'b0, 1'b0, 2'd0);
    chk_y("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
    send(8'h10, 1'b1);
    chk_flags("rf_s0", 1'b0, 1'b0, 1'b1, 2'd1);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    chk_flags("rf_s2", 1'b0, 1'b0, 1'b1, 2'd3);
    send(8'h13, 1'b0);
    chk_flags("rf_s3", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_y("rf_s3", 8'h10, 8'h11, 8'h12, 8'h13);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
